// File: rtl/router_mp.sv
// router_mp: one packet input stream routed into NUM_PORTS output FIFOs, with parity checking.
// Define ROUTER_MP_TIMEOUT_EN to flush any port whose data sits unread for TIMEOUT cycles.
module router_mp #(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 30
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid,
    input  logic [DATA_W-1:0]           data_in,
    input  logic [NUM_PORTS-1:0]        read_enb,
    output logic                        busy,
    output logic                        err,
    output logic                        addr_err,
    output logic [NUM_PORTS-1:0]        vld_out,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS-1:0]        timeout
);
    localparam int ADDR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W:0] PORTS_L = (ADDR_W+1)'(NUM_PORTS);
    localparam logic [LEN_W:0]  REM_ONE = (LEN_W+1)'(1);
    localparam logic [LEN_W:0]  REM_TWO = (LEN_W+1)'(2);

    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : gBadPorts
        $error("router_mp: NUM_PORTS must be in 2..8");
    end
    if (DATA_W < ADDR_W + 2) begin : gBadWidth
        $error("router_mp: DATA_W must be at least ADDR_W+2");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("router_mp: DEPTH must be a power of 2 and at least 4");
    end
    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : gBadTimeout
        $error("router_mp: TIMEOUT must be in 2..1023");
    end

    typedef enum logic [2:0] {IDLE, ROUTE, LOAD, PARITY, CHECK, DROP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     dest_q, dest_d;
    logic [DATA_W-1:0]     hdr_q, hdr_d;
    logic [LEN_W:0]        remCnt_q, remCnt_d;
    logic [DATA_W-1:0]     par_q, par_d;
    logic                  parErr_q, parErr_d;
    logic                  addrErr_q, addrErr_d;

    logic [DATA_W-1:0]     mem_q   [NUM_PORTS][DEPTH];
    logic [PTR_W-1:0]      wrPtr_q [NUM_PORTS];
    logic [PTR_W-1:0]      rdPtr_q [NUM_PORTS];
    logic [CNT_W-1:0]      count_q [NUM_PORTS];
    logic [DATA_W-1:0]     dout_q  [NUM_PORTS];

    logic [NUM_PORTS-1:0]  full, wrEn, rdEn, flush;
    logic                  fifoWr, accept, destFull, destFlush;
    logic [DATA_W-1:0]     wrData;
    logic [ADDR_W-1:0]     inDest;
    logic [LEN_W-1:0]      inLen;

    assign inDest   = data_in[ADDR_W-1:0];
    assign inLen    = data_in[DATA_W-1:ADDR_W];
    assign err      = (state_q == CHECK) && parErr_q;
    assign addr_err = addrErr_q;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            full[i]    = (count_q[i] == CNT_W'(DEPTH));
            vld_out[i] = (count_q[i] != '0);
            rdEn[i]    = read_enb[i] && (count_q[i] != '0);
            wrEn[i]    = fifoWr && (dest_q == ADDR_W'(i));
            data_out[i*DATA_W +: DATA_W] = dout_q[i];
        end
    end

`ifdef ROUTER_MP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] toCnt_q [NUM_PORTS];

    // The pulse marks the idle cycle that brings the count to TIMEOUT; the FIFO empties at its end.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            flush[i] = (count_q[i] != '0) && !read_enb[i] && (toCnt_q[i] == TO_W'(TIMEOUT - 1));
        end
    end
    assign timeout = flush;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst || flush[i] || read_enb[i] || count_q[i] == '0) toCnt_q[i] <= '0;
            else                                                    toCnt_q[i] <= toCnt_q[i] + TO_W'(1);
        end
    end
`else
    assign flush   = '0;
    assign timeout = '0;
`endif

    // remCnt counts the bytes still owed after the header, parity byte included.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        hdr_d     = hdr_q;
        remCnt_d  = remCnt_q;
        par_d     = par_q;
        parErr_d  = parErr_q;
        addrErr_d = 1'b0;
        busy      = 1'b0;
        fifoWr    = 1'b0;
        accept    = 1'b0;
        wrData    = data_in;
        destFull  = full[dest_q];
        destFlush = flush[dest_q];
        case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    hdr_d    = data_in;
                    par_d    = data_in;
                    remCnt_d = {1'b0, inLen} + REM_ONE;
                    if ({1'b0, inDest} < PORTS_L) begin
                        dest_d  = inDest;
                        state_d = ROUTE;
                    end else begin
                        addrErr_d = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            ROUTE: begin
                busy   = 1'b1;
                wrData = hdr_q;
                if (destFlush)     state_d = DROP;
                else if (!destFull) begin
                    fifoWr  = 1'b1;
                    state_d = (remCnt_q == REM_ONE) ? PARITY : LOAD;
                end
            end
            LOAD: begin
                busy   = destFull;
                accept = pkt_valid && !destFull;
                if (accept) begin
                    remCnt_d = remCnt_q - REM_ONE;
                    par_d    = par_q ^ data_in;
                    fifoWr   = !destFlush;
                end
                if (destFlush)                          state_d = DROP;
                else if (accept && remCnt_q == REM_TWO) state_d = PARITY;
            end
            PARITY: begin
                busy   = destFull;
                accept = pkt_valid && !destFull;
                if (accept) begin
                    parErr_d = (par_q != data_in);
                    fifoWr   = !destFlush;
                    state_d  = destFlush ? IDLE : CHECK;
                end else if (destFlush) begin
                    state_d = DROP;
                end
            end
            CHECK: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            DROP: begin
                if (pkt_valid) begin
                    remCnt_d = remCnt_q - REM_ONE;
                    if (remCnt_q == REM_ONE) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            hdr_q     <= '0;
            remCnt_q  <= '0;
            par_q     <= '0;
            parErr_q  <= 1'b0;
            addrErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            hdr_q     <= hdr_d;
            remCnt_q  <= remCnt_d;
            par_q     <= par_d;
            parErr_q  <= parErr_d;
            addrErr_q <= addrErr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst || flush[i]) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
                count_q[i] <= '0;
            end else begin
                if (wrEn[i]) wrPtr_q[i] <= wrPtr_q[i] + PTR_W'(1);
                if (rdEn[i]) rdPtr_q[i] <= rdPtr_q[i] + PTR_W'(1);
                case ({wrEn[i], rdEn[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNT_W'(1);
                    2'b01:   count_q[i] <= count_q[i] - CNT_W'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
            if (rst)           dout_q[i] <= '0;
            else if (rdEn[i])  dout_q[i] <= mem_q[i][rdPtr_q[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wrEn[i]) mem_q[i][wrPtr_q[i]] <= wrData;
        end
    end

endmodule

// File: tb/tb_router_mp.sv
// tb_router_mp: table vectors, directed corner sequences and a randomized run against a queue model.
// Timeout behaviour is checked when ROUTER_MP_TIMEOUT_EN is defined, its absence otherwise.
`timescale 1ns/1ps
module tb_router_mp;
    localparam int NUM_PORTS = 3;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int TIMEOUT   = 30;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        pkt_valid;
    logic [DATA_W-1:0]           data_in;
    logic [NUM_PORTS-1:0]        read_enb;
    logic                        busy, err, addr_err;
    logic [NUM_PORTS-1:0]        vld_out, timeout;
    logic [NUM_PORTS*DATA_W-1:0] data_out;

    router_mp #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in), .read_enb(read_enb),
        .busy(busy), .err(err), .addr_err(addr_err), .vld_out(vld_out),
        .data_out(data_out), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      hdr;
        int              nPay;
        logic [3:0][7:0] pay;
        logic [7:0]      par;
        int              port;
        int              expErr;
        int              expAddrErr;
    } vec_t;

    vec_t       vecs [8];
    int         testsRun = 0, testsFailed = 0;
    int         errSeen = 0, addrErrSeen = 0, busySeen = 0, timeoutSeen = 0;
    int         vld2Cycles = 0, toAt = -1;
    logic [7:0] expQ [NUM_PORTS][$];
    logic [7:0] txQ[$];
    logic [7:0] q[$];
    logic [7:0] gotQ[$];
    logic [7:0] got, par;
    int         expErrs = 0, expAddr = 0, idx, guard, cycles;
    logic [NUM_PORTS-1:0] rd;
    logic       acc;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        errSeen     += int'(err);
        addrErrSeen += int'(addr_err);
        busySeen    |= int'(busy);
        timeoutSeen |= int'(timeout != '0);
        if (vld_out[2]) vld2Cycles++;
        if (timeout[2] && toAt < 0) toAt = vld2Cycles;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit accepted;
        int g = 0;
        pkt_valid = 1'b1;
        data_in   = b;
        do begin
            accepted = !busy;
            tick();
            g++;
        end while (!accepted && g < 500);
        if (!accepted) failNow("send byte");
        pkt_valid = 1'b0;
    endtask

    task automatic readByte(input int p, output logic [7:0] b);
        int g = 0;
        while (!vld_out[p] && g < 100) begin
            tick();
            g++;
        end
        if (!vld_out[p]) failNow($sformatf("read port %0d", p));
        read_enb[p] = 1'b1;
        tick();
        read_enb = '0;
        b = data_out[p*DATA_W +: DATA_W];
    endtask

    task automatic applyStimulus(input vec_t v);
        errSeen = 0;
        addrErrSeen = 0;
        busySeen = 0;
        sendByte(v.hdr);
        for (int k = 0; k < v.nPay; k++) sendByte(v.pay[k]);
        sendByte(v.par);
        repeat (3) tick();
    endtask

    task automatic verifyVector(input vec_t v, input int n);
        logic [7:0] b;
        checkOutput($sformatf("vec%0d err pulses", n), errSeen, v.expErr);
        checkOutput($sformatf("vec%0d addr_err pulses", n), addrErrSeen, v.expAddrErr);
        for (int p = 0; p < NUM_PORTS; p++)
            if (p != v.port) checkOutput($sformatf("vec%0d vld_out[%0d] idle", n, p), vld_out[p], 0);
        if (v.port < 0) begin
            checkOutput($sformatf("vec%0d busy during drop", n), busySeen, 0);
        end else begin
            readByte(v.port, b);
            checkOutput($sformatf("vec%0d header", n), b, v.hdr);
            for (int k = 0; k < v.nPay; k++) begin
                readByte(v.port, b);
                checkOutput($sformatf("vec%0d payload %0d", n, k), b, v.pay[k]);
            end
            readByte(v.port, b);
            checkOutput($sformatf("vec%0d parity byte", n), b, v.par);
            checkOutput($sformatf("vec%0d drained", n), vld_out[v.port], 0);
        end
    endtask

    // Random packet: its bytes go to the sender queue, and to the expected queue of a valid port.
    task automatic genPacket();
        int d, len;
        logic [7:0] hdr, p, b;
        bit bad;
        d   = $urandom_range(3);
        len = $urandom_range(12);
        hdr = 8'((len << 2) | d);
        p   = hdr;
        txQ.push_back(hdr);
        if (d < NUM_PORTS) expQ[d].push_back(hdr);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            p ^= b;
            txQ.push_back(b);
            if (d < NUM_PORTS) expQ[d].push_back(b);
        end
        bad = ($urandom_range(3) == 0);
        if (bad) p ^= 8'(1 << $urandom_range(7));
        txQ.push_back(p);
        if (d < NUM_PORTS) begin
            expQ[d].push_back(p);
            expErrs += int'(bad);
        end else begin
            expAddr++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Parity of 0D,11,22,33 is 0D; 0E,01,02,03 gives 0E; 12,FF,00,80,01 gives 6C.
        vecs[0] = '{8'h0D, 3, {8'h00, 8'h33, 8'h22, 8'h11}, 8'h0D, 1, 0, 0};
        vecs[1] = '{8'h0D, 3, {8'h00, 8'h33, 8'h22, 8'h11}, 8'h00, 1, 1, 0};
        vecs[2] = '{8'h07, 1, {8'h00, 8'h00, 8'h00, 8'hAA}, 8'hBB, -1, 0, 1};
        vecs[3] = '{8'h00, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 0, 0, 0};
        vecs[4] = '{8'h0E, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 8'h0E, 2, 0, 0};
        vecs[5] = '{8'h0D, 3, {8'h00, 8'h33, 8'h22, 8'h11}, 8'h1D, 1, 1, 0};
        vecs[6] = '{8'h0F, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 8'h55, -1, 0, 1};
        vecs[7] = '{8'h12, 4, {8'h01, 8'h80, 8'h00, 8'hFF}, 8'h6C, 2, 0, 0};

        rst = 1'b1;
        pkt_valid = 1'b0;
        data_in = '0;
        read_enb = '0;
        repeat (2) tick();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset addr_err", addr_err, 0);
        checkOutput("reset vld_out", vld_out, 0);
        checkOutput("reset timeout", timeout, 0);
        checkOutput("reset data_out", data_out, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            verifyVector(vecs[i], i);
        end

        // LEN 20 to port 0 with no reads: FIFO fills after 16 writes, then reads release it.
        q = {};
        par = 8'h50;
        q.push_back(8'h50);
        for (int k = 1; k <= 20; k++) begin
            q.push_back(8'(k));
            par ^= 8'(k);
        end
        q.push_back(par);
        errSeen = 0;
        for (int k = 0; k < 15; k++) sendByte(q[k]);
        checkOutput("busy after 15 writes", busy, 0);
        sendByte(q[15]);
        checkOutput("busy after 16 writes", busy, 1);
        pkt_valid = 1'b1;
        data_in = q[16];
        repeat (4) tick();
        checkOutput("busy held while full", busy, 1);
        checkOutput("full port vld_out", vld_out, 3'b001);
        idx = 16;
        guard = 0;
        gotQ = {};
        while (gotQ.size() < 22 && guard < 500) begin
            pkt_valid = (idx < 22);
            if (idx < 22) data_in = q[idx];
            read_enb = {2'b00, vld_out[0]};
            acc = pkt_valid && !busy;
            rd = read_enb;
            tick();
            if (acc) idx++;
            if (rd[0]) gotQ.push_back(data_out[7:0]);
            guard++;
        end
        pkt_valid = 1'b0;
        read_enb = '0;
        repeat (2) tick();
        checkOutput("long packet byte count", gotQ.size(), 22);
        for (int k = 0; k < 22 && k < gotQ.size(); k++)
            checkOutput($sformatf("long packet byte %0d", k), gotQ[k], q[k]);
        checkOutput("long packet err", errSeen, 0);

        // Reset after header and two payload bytes discards the packet.
        sendByte(8'h0D);
        sendByte(8'h11);
        sendByte(8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid-reset busy", busy, 0);
        checkOutput("mid-reset vld_out", vld_out, 0);
        checkOutput("mid-reset data_out", data_out, 0);
        checkOutput("mid-reset err", err, 0);
        checkOutput("mid-reset addr_err", addr_err, 0);
        applyStimulus(vecs[0]);
        verifyVector(vecs[0], 0);

        vld2Cycles = 0;
        toAt = -1;
        timeoutSeen = 0;
        sendByte(8'h02);
        sendByte(8'h02);
`ifdef ROUTER_MP_TIMEOUT_EN
        guard = 0;
        while (toAt < 0 && guard < 100) begin
            tick();
            guard++;
        end
        if (toAt < 0) failNow("timeout pulse");
        checkOutput("timeout cycle", toAt, TIMEOUT);
        tick();
        checkOutput("vld_out[2] after flush", vld_out[2], 0);
        checkOutput("timeout single pulse", timeout, 0);
`else
        repeat (100) tick();
        checkOutput("no timeout pulse", timeoutSeen, 0);
        checkOutput("port 2 still holds data", vld_out[2], 1);
        readByte(2, got);
        checkOutput("held header", got, 8'h02);
        readByte(2, got);
        checkOutput("held parity", got, 8'h02);
`endif

        // Random packets with idle gaps and random reads, checked against per-port queues.
        errSeen = 0;
        addrErrSeen = 0;
        cycles = 0;
        for (int n = 0; n < 40 || txQ.size() > 0 || expQ[0].size() > 0 || expQ[1].size() > 0
                        || expQ[2].size() > 0; ) begin
            if (cycles >= 20000) break;
            if (txQ.size() == 0 && n < 40) begin
                genPacket();
                n++;
            end
            pkt_valid = (txQ.size() > 0) && ($urandom_range(3) != 0);
            data_in = pkt_valid ? txQ[0] : 8'($urandom);
            read_enb = 3'($urandom);
            acc = pkt_valid && !busy;
            rd = read_enb & vld_out;
            tick();
            cycles++;
            if (acc) void'(txQ.pop_front());
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd[p]) begin
                    if (expQ[p].size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL random extra read port %0d: got 0x%0h, expected none",
                                 p, data_out[p*DATA_W +: DATA_W]);
                    end else begin
                        checkOutput($sformatf("random data port %0d", p),
                                    data_out[p*DATA_W +: DATA_W], expQ[p].pop_front());
                    end
                end
            end
        end
        if (cycles >= 20000) failNow("random run");
        pkt_valid = 1'b0;
        read_enb = '0;
        repeat (3) tick();
        checkOutput("random err count", errSeen, expErrs);
        checkOutput("random addr_err count", addrErrSeen, expAddr);
        checkOutput("random final vld_out", vld_out, 0);
        checkOutput("random final busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
